seq_detector_param: RTL

//  Parametrised serial sequence detector: watches a 1-bit stream w and flags every

---
 rtl/seq_detector_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. KMP progress state, overlap/non-overlap,
// Mealy/Moore match flag and a saturating match counter, all selected at elaboration.
module seq_detector_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MEALY   = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             w,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned SW     = $clog2(N + 1);
  localparam int unsigned MAX_ST = MEALY ? N - 1 : N;
  localparam logic [SW-1:0] MATCH_ST = SW'(N);

  // Longest proper border of PATTERN (prefix that is also a suffix).
  function automatic int unsigned calc_border();
    int unsigned b;
    bit ok;
    b = 0;
    for (int l = 1; l < int'(N); l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (PATTERN[N-1-i] != PATTERN[l-1-i]) ok = 1'b0;
      end
      if (ok) b = l;
    end
    return b;
  endfunction

  // Progress after appending wb to a history whose longest matching prefix has length k.
  function automatic int unsigned calc_next(int k, bit wb);
    logic [N:0] s;
    bit ok;
    s = '0;
    for (int j = 0; j < k; j++) s[j] = PATTERN[N-1-j];
    s[k] = wb;
    for (int l = k + 1; l >= 1; l--) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (s[k+1-l+i] != PATTERN[N-1-i]) ok = 1'b0;
      end
      if (ok) return l;
    end
    return 0;
  endfunction

  function automatic logic [2*N*SW-1:0] build_tbl();
    logic [2*N*SW-1:0] t;
    t = '0;
    for (int k = 0; k < int'(N); k++) begin
      for (int b = 0; b < 2; b++) begin
        t[(2*k+b)*SW +: SW] = SW'(calc_next(k, b[0]));
      end
    end
    return t;
  endfunction

  localparam int unsigned       BORDER   = calc_border();
  localparam logic [SW-1:0]     BASE     = OVERLAP ? SW'(BORDER) : '0;
  localparam logic [2*N*SW-1:0] NEXT_TBL = build_tbl();

  logic [SW-1:0]    state_q, state_d, k_eff, k_nxt;
  logic [CNT_W-1:0] cnt_d;
  logic             z_q;
  logic             valid_st, hit;
  int unsigned      idx;

  always_comb begin
    valid_st = 32'(state_q) <= MAX_ST;
    // Moore MATCH behaves like the post-match restart point for the next sample.
    k_eff    = (!MEALY && state_q == MATCH_ST) ? BASE : state_q;
    idx      = 2 * 32'(k_eff) + 32'(w);
    k_nxt    = valid_st ? NEXT_TBL[idx*SW +: SW] : '0;
    hit      = en & ~clr & valid_st & (k_nxt == MATCH_ST);

    state_d = state_q;
    if (clr || !valid_st) begin
      state_d = '0;
    end else if (en) begin
      if (hit) state_d = MEALY ? BASE : MATCH_ST;
      else     state_d = k_nxt;
    end

    cnt_d = match_cnt;
    if (clr)                   cnt_d = '0;
    else if (hit && !cnt_sat)  cnt_d = match_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      match_cnt <= '0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_cnt <= cnt_d;
      z_q       <= (state_d == MATCH_ST);
    end
  end

  assign z       = MEALY ? (hit & ~rst) : z_q;
  assign cnt_sat = &match_cnt;

endmodule
